// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file: FSM states,
// the hardwired-zero index and a packed-bus slice extractor.
package reg_file_pkg;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } stateT;

   localparam int ZERO_REG = 0;

   // Generous upper bounds so one helper serves every legal parameter set
   localparam int VEC_W   = 256;
   localparam int FIELD_W = 64;

   function automatic logic [FIELD_W-1:0] portSlice(input logic [VEC_W-1:0] vec,
                                                    input int k,
                                                    input int w);
      logic [VEC_W-1:0] shifted;
      logic [VEC_W-1:0] mask;
      shifted = vec >> (k * w);
      mask    = (VEC_W'(1) << w) - VEC_W'(1);
      return FIELD_W'(shifted & mask);
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register file: write port, read ports,
// issue (scoreboard set) port and the ready flag.
interface reg_file_mp_if #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = 2
);

   logic                     reg_write;
   logic [ADDR_W-1:0]        AddrD;
   logic [WIDTH-1:0]         DataD;
   logic [NUM_RD*ADDR_W-1:0] AddrR;
   logic [NUM_RD*WIDTH-1:0]  DataR;
   logic [NUM_RD-1:0]        busy_r;
   logic                     issue_valid;
   logic [ADDR_W-1:0]        issue_addr;
   logic                     ready;

   modport master (
      output reg_write, AddrD, DataD, AddrR, issue_valid, issue_addr,
      input  DataR, busy_r, ready
   );

   modport slave (
      input  reg_write, AddrD, DataD, AddrR, issue_valid, issue_addr,
      output DataR, busy_r, ready
   );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register pending bits used for hazard detection; x0 is never pending.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              setEn,
   input  logic [ADDR_W-1:0] setAddr,
   input  logic              clrEn,
   input  logic [ADDR_W-1:0] clrAddr,
   output logic [DEPTH-1:0]  pending
);

   logic [DEPTH-1:0] nextPending;

   // A set beats a clear on the same register: the newly issued producer
   // supersedes the one that is just retiring.
   always_comb begin
      nextPending = pending;
      if (clrEn) begin
         nextPending[clrAddr] = 1'b0;
      end
      if (setEn) begin
         nextPending[setAddr] = 1'b1;
      end
      nextPending[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= nextPending;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired x0, optional write bypass,
// pending scoreboard and a one-entry-per-cycle clearing sequencer after reset.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_mp_if.slave bus
);

   stateT             state;
   stateT             nextState;
   logic [ADDR_W-1:0] clrCnt;
   logic [ADDR_W-1:0] nextClrCnt;

   logic              running;
   logic              writeLive;
   logic              issueLive;

   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [WIDTH-1:0]  memData;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic [DEPTH-1:0]  pending;
   logic [ADDR_W-1:0] rdAddr [NUM_RD];
   logic [NUM_RD*WIDTH-1:0] dataR;
   logic [NUM_RD-1:0]       busyR;

   assign running   = (state == ST_RUN);
   assign writeLive = running && bus.reg_write && (bus.AddrD != ADDR_W'(ZERO_REG));
   assign issueLive = running && bus.issue_valid && (bus.issue_addr != ADDR_W'(ZERO_REG));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_INIT;
         clrCnt <= '0;
      end else begin
         state  <= nextState;
         clrCnt <= nextClrCnt;
      end
   end

   // INIT walks the array writing zeros; in RUN the single write port belongs
   // to writeback.
   always_comb begin
      nextState  = state;
      nextClrCnt = clrCnt;
      memWe      = 1'b0;
      memAddr    = clrCnt;
      memData    = '0;
      case (state)
         ST_INIT: begin
            memWe      = 1'b1;
            nextClrCnt = clrCnt + 1'b1;
            if (clrCnt == ADDR_W'(DEPTH - 1)) begin
               nextState = ST_RUN;
            end
         end
         ST_RUN: begin
            if (writeLive) begin
               memWe   = 1'b1;
               memAddr = bus.AddrD;
               memData = bus.DataD;
            end
         end
         default: begin
            nextState = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n && memWe) begin
         mem[memAddr] <= memData;
      end
   end

   reg_scoreboard #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .setEn   (issueLive),
      .setAddr (bus.issue_addr),
      .clrEn   (writeLive),
      .clrAddr (bus.AddrD),
      .pending (pending)
   );

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         rdAddr[k] = ADDR_W'(portSlice(VEC_W'(bus.AddrR), k, ADDR_W));
      end
   end

   // A bypassed write also retires its producer this cycle, so the port sees
   // not-busy unless the same register is being re-issued right now.
   always_comb begin
      dataR = '0;
      busyR = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (running && (rdAddr[k] != ADDR_W'(ZERO_REG))) begin
            if ((BYPASS != 0) && writeLive && (rdAddr[k] == bus.AddrD)) begin
               dataR[k*WIDTH +: WIDTH] = bus.DataD;
               busyR[k] = pending[rdAddr[k]] && issueLive && (bus.issue_addr == rdAddr[k]);
            end else begin
               dataR[k*WIDTH +: WIDTH] = mem[rdAddr[k]];
               busyR[k] = pending[rdAddr[k]];
            end
         end
      end
   end

   assign bus.DataR  = dataR;
   assign bus.busy_r = busyR;
   assign bus.ready  = running;

endmodule

// File: tb/tb_reg_file_mp.sv
// Drives a bypassing and a non-bypassing register file with identical traffic
// and compares both against an array/queue-level reference model.
module tb_reg_file_mp;
   import reg_file_pkg::*;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int AW = $clog2(D);
   localparam int NR = 2;

   logic          clk;
   logic          rstN;
   logic          we;
   logic [AW-1:0] wa;
   logic [W-1:0]  wd;
   logic          iv;
   logic [AW-1:0] ia;
   logic [AW-1:0] ra [NR];

   logic [W-1:0]  mMem [D];
   bit            mPend [D];
   bit            mRun;
   int            mCnt;

   int            checks;
   int            errors;

   reg_file_mp_if #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR)) ifB ();
   reg_file_mp_if #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR)) ifN ();

   reg_file_mp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dutB (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (ifB)
   );

   reg_file_mp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dutN (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (ifN)
   );

   assign ifB.reg_write   = we;
   assign ifB.AddrD       = wa;
   assign ifB.DataD       = wd;
   assign ifB.issue_valid = iv;
   assign ifB.issue_addr  = ia;
   assign ifB.AddrR       = {ra[1], ra[0]};
   assign ifN.reg_write   = we;
   assign ifN.AddrD       = wa;
   assign ifN.DataD       = wd;
   assign ifN.issue_valid = iv;
   assign ifN.issue_addr  = ia;
   assign ifN.AddrR       = {ra[1], ra[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic rn, input logic w, input int waddr,
                                input logic [W-1:0] wdat, input logic i, input int iaddr,
                                input int r0, input int r1);
      rstN  = rn;
      we    = w;
      wa    = AW'(waddr);
      wd    = wdat;
      iv    = i;
      ia    = AW'(iaddr);
      ra[0] = AW'(r0);
      ra[1] = AW'(r1);
      #1;
   endtask

   // Reference: what a read port should show given the architectural state
   function automatic logic [W-1:0] expData(input int k, input bit byp);
      if (!mRun || ra[k] == 0) return '0;
      if (byp && we && wa != 0 && wa == ra[k]) return wd;
      return mMem[ra[k]];
   endfunction

   function automatic logic expBusy(input int k, input bit byp);
      if (!mRun || ra[k] == 0) return 1'b0;
      if (byp && we && wa == ra[k] && !(iv && ia == ra[k])) return 1'b0;
      return mPend[ra[k]];
   endfunction

   task automatic checkOne(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, ".B.ready"}, W'(ifB.ready), W'(mRun));
      checkOne({tag, ".N.ready"}, W'(ifN.ready), W'(mRun));
      for (int k = 0; k < NR; k++) begin
         checkOne($sformatf("%s.B.data%0d", tag, k),
                  W'(portSlice(VEC_W'(ifB.DataR), k, W)), expData(k, 1'b1));
         checkOne($sformatf("%s.N.data%0d", tag, k),
                  W'(portSlice(VEC_W'(ifN.DataR), k, W)), expData(k, 1'b0));
         checkOne($sformatf("%s.B.busy%0d", tag, k), W'(ifB.busy_r[k]), W'(expBusy(k, 1'b1)));
         checkOne($sformatf("%s.N.busy%0d", tag, k), W'(ifN.busy_r[k]), W'(expBusy(k, 1'b0)));
      end
   endtask

   // Advance the model by one rising edge, then let the DUT take the same edge
   task automatic tick();
      if (!rstN) begin
         mRun = 1'b0;
         mCnt = 0;
         foreach (mPend[i]) mPend[i] = 1'b0;
      end else if (!mRun) begin
         mMem[mCnt] = '0;
         mCnt++;
         if (mCnt == D) mRun = 1'b1;
      end else begin
         if (we && wa != 0) begin
            mMem[wa]  = wd;
            mPend[wa] = 1'b0;
         end
         if (iv && ia != 0) mPend[ia] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mRun   = 1'b0;
      mCnt   = 0;
      foreach (mMem[i]) mMem[i] = '0;
      foreach (mPend[i]) mPend[i] = 1'b0;

      applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, 0, 5, 5);
      tick();
      tick();
      checkOutput("reset");

      for (int e = 1; e <= D; e++) begin
         applyStimulus(1'b1, 1'b1, 2, 32'h55, 1'b1, 2, 5, 2);
         checkOutput($sformatf("init%0d", e));
         tick();
      end
      checkOne("init.readyAfter32", W'(ifB.ready), W'(1));

      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, 2, 5);
      checkOutput("ignoredInit");
      checkOne("ignoredInit.x2zero", W'(portSlice(VEC_W'(ifB.DataR), 0, W)), '0);

      applyStimulus(1'b1, 1'b1, 7, 32'hDEADBEEF, 1'b0, 0, 7, 7);
      checkOutput("wr7.same");
      tick();
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, 7, 7);
      checkOutput("wr7.next");
      checkOne("wr7.port1", W'(portSlice(VEC_W'(ifN.DataR), 1, W)), 32'hDEADBEEF);

      applyStimulus(1'b1, 1'b1, 0, 32'h1234, 1'b0, 0, 0, 0);
      checkOutput("wrx0.same");
      tick();
      checkOutput("wrx0.next");

      applyStimulus(1'b1, 1'b1, 3, 32'hA5A5A5A5, 1'b0, 0, 7, 3);
      checkOutput("bypass.same");
      checkOne("bypass.B.port1", W'(portSlice(VEC_W'(ifB.DataR), 1, W)), 32'hA5A5A5A5);
      checkOne("bypass.N.port1", W'(portSlice(VEC_W'(ifN.DataR), 1, W)), 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, 7, 3);
      checkOutput("bypass.next");

      applyStimulus(1'b1, 1'b0, 0, '0, 1'b1, 9, 9, 0);
      checkOutput("sb.issue");
      tick();
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, 9, 9);
      checkOutput("sb.pending");
      checkOne("sb.busy9", W'(ifN.busy_r[0]), W'(1));
      applyStimulus(1'b1, 1'b1, 9, 32'h99, 1'b0, 0, 9, 9);
      checkOutput("sb.write");
      tick();
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b1, 9, 9, 9);
      checkOutput("sb.cleared");
      checkOne("sb.clear9", W'(ifN.busy_r[0]), W'(0));
      tick();
      applyStimulus(1'b1, 1'b1, 9, 32'h77, 1'b1, 9, 9, 9);
      checkOutput("sb.both");
      tick();
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, 9, 9);
      checkOutput("sb.setWins");
      checkOne("sb.stays1", W'(ifN.busy_r[1]), W'(1));

      for (int n = 0; n < 200; n++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         checkOutput($sformatf("rand%0d", n));
         tick();
      end

      applyStimulus(1'b1, 1'b1, 4, 32'hFFFFFFFF, 1'b1, 4, 4, 4);
      tick();
      applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, 4, 4);
      checkOutput("midRst.before");
      applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, 0, 4, 4);
      tick();
      checkOutput("midRst.after");
      for (int e = 1; e <= D; e++) begin
         applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, 4, 4);
         tick();
      end
      checkOutput("midRst.x4");
      checkOne("midRst.x4zero", W'(portSlice(VEC_W'(ifB.DataR), 0, W)), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the RISC-V core: the next generation of the 32x32 register file. It adds a hardwired-zero x0, optional write-to-read bypass, a per-register pending scoreboard for hazard detection, and a synchronous reset that clears the array with a sequencer, one entry per cycle. It sits between decode (reads, issue) and writeback (write port).

## Interface
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers; a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), register address width.
- NUM_RD, 2, number of read ports, 1 to 4.
- BYPASS, 1, 1 = a same-cycle write is visible on matching read ports.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- reg_write  in  1  write enable.
- AddrD  in  ADDR_W  write address.
- DataD  in  WIDTH  write data.
- AddrR  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- DataR  out  NUM_RD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH].
- busy_r  out  NUM_RD  pending bit of the register addressed by each read port.
- issue_valid  in  1  marks a register as pending (an in-flight producer).
- issue_addr  in  ADDR_W  register to mark pending.
- ready  out  1  initialisation finished; the file accepts traffic.

## Operation
- **States.** Two states, INIT and RUN.
- **Reset.** rst_n sampled low at a rising edge: state=INIT, clr_cnt=0, all pending bits=0, ready=0. This applies in any state, including mid-INIT and mid-RUN.
- **INIT.** Each edge with rst_n high writes 0 to entry clr_cnt and increments clr_cnt. The edge that clears entry DEPTH-1 moves the state to RUN and sets ready=1.
- **Inputs ignored in INIT.** reg_write and issue_valid have no effect.
- **Outputs in INIT.** DataR is all zeros and busy_r is all zeros.
- **RUN, writes.** reg_write=1 with AddrD!=0 writes DataD at the edge. A write to x0 is discarded.
- **RUN, reads.** Reads are combinational.
  - AddrR_k==0 gives 0.
  - Otherwise, if BYPASS=1, reg_write=1 and AddrR_k==AddrD, the port returns DataD.
  - Otherwise the port returns the array contents.
- **Scoreboard.**
  - issue_valid with issue_addr!=0 sets pending[issue_addr].
  - reg_write with AddrD!=0 clears pending[AddrD].
  - Set and clear of the same address in one cycle: the set wins, because a new producer supersedes the old one.
  - issue and write to different addresses both take effect.
  - pending[0] is constant 0.
- **busy_r_k.** Equals pending[AddrR_k].
  - If BYPASS=1 and a matching write is in progress without a same-address issue, busy_r_k=0 in that cycle.
  - busy_r_k is 0 whenever AddrR_k==0.
- **Port independence.** Several read ports may use the same address; each returns identical data.

## Timing
- **Reset values.** ready=0, busy_r=0, DataR=0 until RUN.
- **Init length.** ready rises on the DEPTH-th rising edge with rst_n high after reset. With DEPTH=32, that is edge 32.
- **Write latency.** A write is visible on the array path on the cycle after the edge that captures it, or in the same cycle through bypass.
- **Scoreboard latency.** A set or clear is visible on busy_r one cycle after the capturing edge, except for the bypass clear described above.
- **Read path.** Combinational, with no output registers.
- **Reset behaviour.** Reset asserted for one edge restarts INIT and clears every pending bit. There is no partial state.

## Structure
- **Shared package reg_file_pkg** holds:
  - the state enum, ST_INIT / ST_RUN;
  - the zero-register index constant;
  - a helper function that extracts read port k's slice from AddrR and DataR.
- **Sub-module reg_scoreboard** holds the pending-bit array. It has set and clear ports, and its own sync active-low reset.
- **Top level** holds the array, the INIT sequencer, the read muxes and the bypass logic.

## Test plan
- **Reset and init.** Hold rst_n=0 for 2 cycles, then release with DEPTH=32 → ready=0 through edge 31 and 1 from edge 32. Reads of x5 return 0 throughout.
- **Write and read back.** In RUN, write 0xDEADBEEF to x7, then read x7 on ports 0 and 1 → both return 0xDEADBEEF the next cycle. A write of 0x1234 to x0 → reads of x0 return 0.
- **Bypass.** With BYPASS=1, write 0xA5A5A5A5 to x3 while port 1 reads x3 → DataR port 1 = 0xA5A5A5A5 in the same cycle. With BYPASS=0 → the old value appears until the next cycle.
- **Scoreboard.**
  - Issue x9, then the next cycle read x9 → busy_r=1.
  - Write x9 → busy_r=0 the following cycle.
  - Issue x9 and write x9 in the same cycle → busy_r stays 1.
- **Reset mid-operation.** Write 0xFFFF_FFFF to x4, issue x4, then pull rst_n low for one edge mid-RUN → ready=0, busy_r=0. After DEPTH edges, x4 reads 0.
- **Ignored inputs in INIT.** Assert reg_write (x2, 0x55) and issue_valid (x2) during INIT → after ready rises, x2 reads 0 and is not busy.
